// File: rtl/alu_slice4_seq_ctrl.sv
// Sequencer running one WIDTH-bit logic op as WIDTH/4 nibble beats on a 4-bit pipelined ALU slice.
// Optional feature macro ALU_SEQ_ZFLAG_EN adds the rsp_zero all-zero result flag.
module alu_slice4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             s_v_in,
  output logic [3:0]       s_a,
  output logic [3:0]       s_b,
  output logic             s_do_and,
  output logic             s_do_or,
  output logic             s_do_xor,
  output logic             s_do_not,
  output logic             s_do_pass,
  input  logic [3:0]       s_result,
  input  logic             s_v_out
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic             rsp_zero
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB + 1);
  localparam logic [CW-1:0] NIB_C  = CW'(NIB);
  localparam logic [CW-1:0] LAST_C = CW'(NIB - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    beat_cnt, beat_nx;
  logic [CW-1:0]    ret_cnt, ret_nx;
  logic [1:0]       age, age_nx;
  logic [WIDTH-1:0] op_a, op_a_nx;
  logic [WIDTH-1:0] op_b, op_b_nx;
  logic [WIDTH-1:0] res_nx;
  logic [4:0]       sel, sel_nx;
  logic             s_v_in_nx;
  logic [3:0]       s_a_nx, s_b_nx;
  logic             rsp_valid_nx;
  logic             ret_take;
`ifdef ALU_SEQ_ZFLAG_EN
  logic             zero_acc, zero_acc_nx;
  logic             rsp_zero_nx;
`endif

  // Select vector layout is {pass, not, xor, or, and}; opcodes 5-7 select nothing.
  function automatic logic [4:0] decode_op(input logic [2:0] op);
    case (op)
      3'd0:    decode_op = 5'b00001;
      3'd1:    decode_op = 5'b00010;
      3'd2:    decode_op = 5'b00100;
      3'd3:    decode_op = 5'b01000;
      3'd4:    decode_op = 5'b10000;
      default: decode_op = 5'b00000;
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign s_do_and  = sel[0];
  assign s_do_or   = sel[1];
  assign s_do_xor  = sel[2];
  assign s_do_not  = sel[3];
  assign s_do_pass = sel[4];

  always_comb begin
    state_nx     = state;
    beat_nx      = beat_cnt;
    ret_nx       = ret_cnt;
    age_nx       = age;
    op_a_nx      = op_a;
    op_b_nx      = op_b;
    res_nx       = rsp_data;
    sel_nx       = sel;
    s_v_in_nx    = 1'b0;
    s_a_nx       = 4'h0;
    s_b_nx       = 4'h0;
    rsp_valid_nx = rsp_valid;
    ret_take     = 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
    zero_acc_nx  = zero_acc;
    rsp_zero_nx  = rsp_zero;
`endif

    if (age != 2'd2) begin
      age_nx = age + 2'd1;
    end

    // Returns are never legitimate in the first two cycles after accept; this keeps
    // stale pulses from beats aborted by a reset out of a freshly started op.
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx  = ISSUE;
          op_a_nx   = req_a;
          op_b_nx   = req_b;
          sel_nx    = decode_op(req_op);
          s_v_in_nx = 1'b1;
          s_a_nx    = req_a[3:0];
          s_b_nx    = req_b[3:0];
          beat_nx   = ONE_C;
          ret_nx    = '0;
          age_nx    = 2'd0;
`ifdef ALU_SEQ_ZFLAG_EN
          zero_acc_nx = 1'b1;
`endif
        end
      end
      ISSUE: begin
        if (beat_cnt == NIB_C) begin
          state_nx = DRAIN;
        end else begin
          s_v_in_nx = 1'b1;
          s_a_nx    = op_a[4*int'(beat_cnt) +: 4];
          s_b_nx    = op_b[4*int'(beat_cnt) +: 4];
          beat_nx   = beat_cnt + ONE_C;
        end
        ret_take = s_v_out && (age == 2'd2);
      end
      DRAIN: begin
        ret_take = s_v_out && (age == 2'd2);
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (ret_take) begin
      res_nx[4*int'(ret_cnt) +: 4] = s_result;
      ret_nx = ret_cnt + ONE_C;
`ifdef ALU_SEQ_ZFLAG_EN
      zero_acc_nx = zero_acc && (s_result == 4'h0);
`endif
      if (ret_cnt == LAST_C) begin
        state_nx     = RESP;
        rsp_valid_nx = 1'b1;
        sel_nx       = 5'b00000;
`ifdef ALU_SEQ_ZFLAG_EN
        rsp_zero_nx  = zero_acc && (s_result == 4'h0);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      ret_cnt   <= '0;
      age       <= 2'd0;
      op_a      <= '0;
      op_b      <= '0;
      sel       <= 5'b00000;
      s_v_in    <= 1'b0;
      s_a       <= 4'h0;
      s_b       <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
      zero_acc  <= 1'b0;
      rsp_zero  <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      beat_cnt  <= beat_nx;
      ret_cnt   <= ret_nx;
      age       <= age_nx;
      op_a      <= op_a_nx;
      op_b      <= op_b_nx;
      sel       <= sel_nx;
      s_v_in    <= s_v_in_nx;
      s_a       <= s_a_nx;
      s_b       <= s_b_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_data  <= res_nx;
`ifdef ALU_SEQ_ZFLAG_EN
      zero_acc  <= zero_acc_nx;
      rsp_zero  <= rsp_zero_nx;
`endif
    end
  end

endmodule
